// File: rtl/nr_div_pkg.sv
// Shared types and sizing helpers for the non-restoring fixed-point divider.
package nr_div_pkg;

  // Controller states of the sequential divider
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    CORR = 2'd2,
    DONE = 2'd3
  } state_t;

  // Default operand format Q8.8
  localparam int DEF_WIDTH = 16;
  localparam int DEF_FRAC  = 8;

  // Iteration count and counter width for the default format
  localparam int ITER_N     = DEF_WIDTH + DEF_FRAC;
  localparam int ITER_CNT_W = $clog2(ITER_N);

  // One iteration per bit of the pre-shifted dividend
  function automatic int iter_count(input int width, input int frac);
    return width + frac;
  endfunction

  // Counter must hold values 0 .. n-1
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/nr_frac_divider_if.sv
// Start/ready request and result bundle for the fixed-point divider.
interface nr_frac_divider_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             overflow;
  logic             div_by_zero;

  // Requester side
  modport master (
    output start, dividend, divisor,
    input  ready, done, quotient, remainder, overflow, div_by_zero
  );

  // Divider side
  modport slave (
    input  start, dividend, divisor,
    output ready, done, quotient, remainder, overflow, div_by_zero
  );
endinterface

// File: rtl/full_adder.sv
// One-bit full adder cell shared with the multiplier layer array.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/nr_addsub_row.sv
// Combinational (WIDTH+1)-bit controlled add/subtract row built from full adders.
// sub=1 computes p_shifted - d (two's complement via inverted d and carry-in 1),
// sub=0 computes p_shifted + d. qbit is the non-restoring quotient digit.
module nr_addsub_row #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH:0] p_shifted,
  input  logic [WIDTH:0] d,
  input  logic           sub,
  output logic [WIDTH:0] result,
  output logic           qbit
);
  // carry[gi] is the carry into bit gi; the carry out of the sign bit is discarded
  logic [WIDTH:0] carry;

  assign carry[0] = sub;

  generate
    for (genvar gi = 0; gi <= WIDTH; gi++) begin : g_cell
      if (gi < WIDTH) begin : g_fa
        full_adder u_fa (
          .a    (p_shifted[gi]),
          .b    (d[gi] ^ sub),
          .cin  (carry[gi]),
          .s    (result[gi]),
          .cout (carry[gi+1])
        );
      end else begin : g_msb
        // Sign bit: sum only, arithmetic is modulo 2^(WIDTH+1)
        assign result[gi] = p_shifted[gi] ^ (d[gi] ^ sub) ^ carry[gi];
      end
    end
  endgenerate

  assign qbit = ~result[WIDTH];
endmodule

// File: rtl/nr_frac_divider.sv
// Sequential radix-2 non-restoring divider for unsigned Q(WIDTH-FRAC).FRAC operands.
// Computes (dividend << FRAC) / divisor over WIDTH+FRAC iterations, followed by
// one remainder-correction cycle and a one-cycle done pulse.
module nr_frac_divider
  import nr_div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int FRAC  = DEF_FRAC
) (
  input  logic             clk,
  input  logic             rst_n,
  nr_frac_divider_if.slave bus
);

  localparam int N     = iter_count(WIDTH, FRAC);
  localparam int CNT_W = cnt_width(N);

  state_t             state_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [WIDTH-1:0]   d_reg;
  logic [N-1:0]       dvd_reg;
  logic [N-1:0]       q_reg;
  logic [WIDTH:0]     p_reg;

  logic               ready_reg;
  logic               done_reg;
  logic [WIDTH-1:0]   quo_reg;
  logic [WIDTH-1:0]   rem_reg;
  logic               ovf_reg;
  logic               dbz_reg;

  logic [WIDTH:0]     row_p_in;
  logic [WIDTH:0]     row_d;
  logic               row_sub;
  logic [WIDTH:0]     row_result;
  logic               row_qbit;
  logic [WIDTH:0]     p_fix;
  logic               q_ovf;

  // The single add/sub row serves both the iteration step and the final
  // correction: in CORR it adds D to the unshifted remainder.
  assign row_p_in = (state_reg == CORR) ? p_reg : {p_reg[WIDTH-1:0], dvd_reg[N-1]};
  assign row_sub  = (state_reg == CORR) ? 1'b0 : ~p_reg[WIDTH];
  assign row_d    = {1'b0, d_reg};

  nr_addsub_row #(.WIDTH(WIDTH)) u_row (
    .p_shifted (row_p_in),
    .d         (row_d),
    .sub       (row_sub),
    .result    (row_result),
    .qbit      (row_qbit)
  );

  // Negative final remainder is restored by one addition of D
  assign p_fix = p_reg[WIDTH] ? row_result : p_reg;
  // Any quotient bit above WIDTH means the result does not fit
  assign q_ovf = |q_reg[N-1:WIDTH];

  // Controller, iteration datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      d_reg     <= '0;
      dvd_reg   <= '0;
      q_reg     <= '0;
      p_reg     <= '0;
      ready_reg <= 1'b1;
      done_reg  <= 1'b0;
      quo_reg   <= '0;
      rem_reg   <= '0;
      ovf_reg   <= 1'b0;
      dbz_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (ready_reg && bus.start) begin
            ready_reg <= 1'b0;
            ovf_reg   <= 1'b0;
            dbz_reg   <= 1'b0;
            if (bus.divisor == '0) begin
              // Divide by zero skips the iterations entirely
              quo_reg   <= '1;
              rem_reg   <= bus.dividend;
              dbz_reg   <= 1'b1;
              state_reg <= DONE;
            end else begin
              d_reg     <= bus.divisor;
              dvd_reg   <= {bus.dividend, {FRAC{1'b0}}};
              q_reg     <= '0;
              p_reg     <= '0;
              cnt_reg   <= CNT_W'(N - 1);
              state_reg <= CALC;
            end
          end
        end
        CALC: begin
          p_reg   <= row_result;
          q_reg   <= {q_reg[N-2:0], row_qbit};
          dvd_reg <= {dvd_reg[N-2:0], 1'b0};
          cnt_reg <= cnt_reg - 1'b1;
          if (cnt_reg == '0) begin
            state_reg <= CORR;
          end
        end
        CORR: begin
          p_reg     <= p_fix;
          rem_reg   <= p_fix[WIDTH-1:0];
          ovf_reg   <= q_ovf;
          quo_reg   <= q_ovf ? '1 : q_reg[WIDTH-1:0];
          state_reg <= DONE;
        end
        DONE: begin
          done_reg  <= 1'b1;
          ready_reg <= 1'b1;
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
          ready_reg <= 1'b1;
        end
      endcase
    end
  end

  assign bus.ready       = ready_reg;
  assign bus.done        = done_reg;
  assign bus.quotient    = quo_reg;
  assign bus.remainder   = rem_reg;
  assign bus.overflow    = ovf_reg;
  assign bus.div_by_zero = dbz_reg;

endmodule

// File: tb/tb_nr_frac_divider.sv
// Self-checking bench for nr_frac_divider: arithmetic reference model with a
// per-cycle compare process, plus directed vectors with literal expectations.
module tb_nr_frac_divider;

  localparam int WIDTH = 16;
  localparam int FRAC  = 8;
  localparam int N     = WIDTH + FRAC;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic cmp_en = 1'b0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  nr_frac_divider_if #(.WIDTH(WIDTH)) bus ();

  nr_frac_divider #(.WIDTH(WIDTH), .FRAC(FRAC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result {overflow, div_by_zero, quotient, remainder}
  function automatic logic [33:0] model_div(input logic [15:0] a, input logic [15:0] b);
    logic [31:0] num;
    logic [31:0] quo;
    logic [31:0] rem;
    if (b == 16'h0000) return {1'b0, 1'b1, 16'hFFFF, a};
    num = {8'h00, a, 8'h00};
    quo = num / {16'h0000, b};
    rem = num % {16'h0000, b};
    if (quo > 32'h0000_FFFF) return {1'b1, 1'b0, 16'hFFFF, rem[15:0]};
    return {2'b00, quo[15:0], rem[15:0]};
  endfunction

  // Transaction-level model: busy for N+2 cycles (1 for divide by zero)
  logic        m_ready, m_done, m_valid, m_ovf, m_dbz;
  logic [15:0] m_q, m_r;
  logic [33:0] m_pend;
  int          m_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ready <= 1'b1;
      m_done  <= 1'b0;
      m_valid <= 1'b1;
      m_ovf   <= 1'b0;
      m_dbz   <= 1'b0;
      m_q     <= 16'h0000;
      m_r     <= 16'h0000;
      m_pend  <= '0;
      m_cnt   <= 0;
    end else if (m_cnt > 1) begin
      m_cnt <= m_cnt - 1;
    end else if (m_cnt == 1) begin
      m_cnt   <= 0;
      m_done  <= 1'b1;
      m_ready <= 1'b1;
      m_valid <= 1'b1;
      {m_ovf, m_dbz, m_q, m_r} <= m_pend;
    end else begin
      m_done <= 1'b0;
      if (m_ready && bus.start) begin
        m_pend  <= model_div(bus.dividend, bus.divisor);
        m_cnt   <= (bus.divisor == 16'h0000) ? 1 : N + 2;
        m_ready <= 1'b0;
        m_valid <= 1'b0;
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("ready", {31'd0, bus.ready}, {31'd0, m_ready});
      chk("done",  {31'd0, bus.done},  {31'd0, m_done});
      if (m_valid) begin
        chk("quotient",    {16'd0, bus.quotient},     {16'd0, m_q});
        chk("remainder",   {16'd0, bus.remainder},    {16'd0, m_r});
        chk("overflow",    {31'd0, bus.overflow},     {31'd0, m_ovf});
        chk("div_by_zero", {31'd0, bus.div_by_zero},  {31'd0, m_dbz});
      end
    end
  end

  // Wait (bounded) until the divider is ready, leaving the bench on a falling edge
  task automatic wait_ready(input string tag, output bit ok);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!bus.ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    ok = bus.ready;
    if (!ok) chk({tag, " ready_timeout"}, 32'd0, 32'd1);
  endtask

  // Count cycles from the accept edge until done (bounded)
  task automatic wait_done(output int lat);
    lat = 0;
    while (1) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.done || lat >= 60) break;
    end
  endtask

  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] eq, input logic [15:0] er,
                        input logic eovf, input logic edbz, input int elat);
    bit ok;
    int lat;
    wait_ready(tag, ok);
    if (!ok) return;
    bus.dividend = a;
    bus.divisor  = b;
    bus.start    = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk({tag, " ready_low"}, {31'd0, bus.ready}, 32'd0);
    wait_done(lat);
    chk({tag, " latency"}, lat, elat);
    chk({tag, " q"},   {16'd0, bus.quotient},  {16'd0, eq});
    chk({tag, " r"},   {16'd0, bus.remainder}, {16'd0, er});
    chk({tag, " ovf"}, {31'd0, bus.overflow},  {31'd0, eovf});
    chk({tag, " dbz"}, {31'd0, bus.div_by_zero}, {31'd0, edbz});
    $display("op %s: 0x%04h / 0x%04h -> q=0x%04h r=0x%04h ovf=%0b dbz=%0b lat=%0d",
             tag, a, b, bus.quotient, bus.remainder, bus.overflow, bus.div_by_zero, lat);
  endtask

  // Hand-computed vectors
  logic [15:0] vec_a   [10] = '{16'h0300, 16'h0007, 16'h8000, 16'h1234, 16'hFFFF,
                                16'h0001, 16'h0064, 16'h7FFF, 16'h0100, 16'h00FF};
  logic [15:0] vec_b   [10] = '{16'h0200, 16'h0003, 16'h0040, 16'h0000, 16'hFFFF,
                                16'hFFFF, 16'h0007, 16'h0080, 16'h0001, 16'h0001};
  logic [15:0] vec_q   [10] = '{16'h0180, 16'h0255, 16'hFFFF, 16'hFFFF, 16'h0100,
                                16'h0000, 16'h0E49, 16'hFFFE, 16'hFFFF, 16'hFF00};
  logic [15:0] vec_r   [10] = '{16'h0000, 16'h0001, 16'h0000, 16'h1234, 16'h0000,
                                16'h0100, 16'h0001, 16'h0000, 16'h0000, 16'h0000};
  logic        vec_ovf [10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic        vec_dbz [10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  int          vec_lat [10] = '{26, 26, 26, 1, 26, 26, 26, 26, 26, 26};

  initial begin
    bit ok;
    int lat;
    bus.start    = 1'b0;
    bus.dividend = 16'h0000;
    bus.divisor  = 16'h0000;

    // Reset state
    @(posedge clk);
    #1;
    cmp_en = 1'b1;
    chk("rst ready", {31'd0, bus.ready}, 32'd1);
    chk("rst done",  {31'd0, bus.done},  32'd0);
    chk("rst q",     {16'd0, bus.quotient},  32'd0);
    chk("rst r",     {16'd0, bus.remainder}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed operand pairs
    for (int i = 0; i < 10; i++) begin
      run_op($sformatf("vec%0d", i), vec_a[i], vec_b[i], vec_q[i], vec_r[i],
             vec_ovf[i], vec_dbz[i], vec_lat[i]);
    end

    // start held high, operands changed mid-operation
    wait_ready("b2b", ok);
    if (ok) begin
      bus.dividend = 16'h0300;
      bus.divisor  = 16'h0200;
      bus.start    = 1'b1;
      @(posedge clk);
      #1;
      lat = 0;
      while (1) begin
        @(posedge clk);
        #1;
        lat++;
        if (lat == 5) begin
          bus.dividend = 16'h0007;
          bus.divisor  = 16'h0003;
        end
        if (bus.done || lat >= 60) break;
      end
      chk("b2b first latency", lat, 26);
      chk("b2b first q", {16'd0, bus.quotient},  32'h0180);
      chk("b2b first r", {16'd0, bus.remainder}, 32'h0000);
      chk("b2b ready before second accept", {31'd0, bus.ready}, 32'd1);
      $display("op b2b1: q=0x%04h r=0x%04h lat=%0d", bus.quotient, bus.remainder, lat);
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      chk("b2b second accept at N+3", {31'd0, bus.ready}, 32'd0);
      wait_done(lat);
      chk("b2b second latency", lat, 26);
      chk("b2b second q", {16'd0, bus.quotient},  32'h0255);
      chk("b2b second r", {16'd0, bus.remainder}, 32'h0001);
      $display("op b2b2: q=0x%04h r=0x%04h lat=%0d", bus.quotient, bus.remainder, lat);
    end

    // Asynchronous reset in the middle of the iterations
    wait_ready("arst", ok);
    if (ok) begin
      bus.dividend = 16'h0300;
      bus.divisor  = 16'h0200;
      bus.start    = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (10) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("arst ready", {31'd0, bus.ready},       32'd1);
      chk("arst done",  {31'd0, bus.done},        32'd0);
      chk("arst q",     {16'd0, bus.quotient},    32'd0);
      chk("arst r",     {16'd0, bus.remainder},   32'd0);
      chk("arst ovf",   {31'd0, bus.overflow},    32'd0);
      chk("arst dbz",   {31'd0, bus.div_by_zero}, 32'd0);
      $display("op arst: q=0x%04h r=0x%04h ready=%0b", bus.quotient, bus.remainder, bus.ready);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
    end
    run_op("post_rst", 16'h0300, 16'h0200, 16'h0180, 16'h0000, 1'b0, 1'b0, 26);

    repeat (3) @(posedge clk);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time bound
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
